// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants.
//   CLK_FREQ, BAUD     : system clock and line rate
//   BAUD_DIV           : clk cycles per UART bit
//   DEF_DATA_BITS      : default character width
//   DEF_IDLE_CYCLES    : default frame-close timeout, two 10-bit characters
package uart_pkg;
  localparam int CLK_FREQ        = 50_000_000;
  localparam int BAUD            = 115_200;
  localparam int BAUD_DIV        = CLK_FREQ / BAUD;
  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_IDLE_CYCLES = 20 * BAUD_DIV;
endpackage

// File: rtl/uart_rx_axis_if.sv
// uart_rx_axis_if: bundles the byte strobe from the UART receiver and the
// AXI-Stream output of uart_rx_axis.
//   rx_data/rx_valid          : byte input, rx_valid is a one-cycle strobe
//   tdata/tvalid/tlast/tready : AXI-Stream; a beat transfers on a cycle where
//                               tvalid && tready, and while tvalid=1 and
//                               tready=0 the source holds tdata/tlast stable.
// modport master: the uart_rx_axis side. modport slave: the environment side.
interface uart_rx_axis_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tlast;
  logic                 tready;

  modport master (
    input  rx_data, rx_valid, tready,
    output tdata, tvalid, tlast
  );

  modport slave (
    output rx_data, rx_valid, tready,
    input  tdata, tvalid, tlast
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO.
//   clk, rst      : clock, asynchronous active-low reset
//   wr_en/wr_data : push request and data
//   rd_en/rd_data : pop request; rd_data shows the head entry (0 when empty)
//   count         : occupancy, 0..DEPTH
//   full, empty   : occupancy flags
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Empty FIFO presents zeros so the outputs follow reset immediately.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers are exactly AW bits so they wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: turns UART receiver byte strobes into an AXI-Stream with
// idle-delimited frames.
//   clk, rst             : clock, asynchronous active-low reset
//   rx_data, rx_valid    : byte and one-cycle strobe from the UART receiver
//   m_axis_tdata/tvalid/tlast/tready : AXI-Stream output (first-word-fall-through)
//   fifo_count           : FIFO occupancy
//   overflow             : sticky, set when an incoming byte is dropped
//   overflow_clr         : synchronous clear of overflow (a same-cycle drop wins)
// Each byte waits in a one-entry hold register until the next byte arrives
// (pushed with last=0) or the line stays idle for IDLE_CYCLES (pushed with
// last=1). Holding one byte back is what lets tlast be attached to it.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int FIFO_DEPTH  = 16,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_valid,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr
);
  localparam int TW = $clog2(IDLE_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(IDLE_CYCLES);

  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 overflow_q, overflow_d;
  logic                 drop;

  logic                 fifo_wr_en;
  logic [DATA_BITS:0]   fifo_wr_data;
  logic [DATA_BITS:0]   fifo_rd_data;
  logic                 fifo_full, fifo_empty;
  logic                 pop, push_ok;

  // empty is exactly fifo_count == 0.
  assign m_axis_tvalid = !fifo_empty;
  assign pop           = m_axis_tvalid && m_axis_tready;
  // A full FIFO still takes a push when its head leaves in the same cycle.
  assign push_ok       = !fifo_full || pop;

  always_comb begin
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    timer_d      = timer_q;
    drop         = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = {1'b0, hold_q};

    if (rx_valid) begin
      // A new byte always beats an expiring timer, so no tlast here.
      timer_d = '0;
      if (!hold_vld_q) begin
        hold_d     = rx_data;
        hold_vld_d = 1'b1;
      end else if (push_ok) begin
        fifo_wr_en   = 1'b1;
        fifo_wr_data = {1'b0, hold_q};
        hold_d       = rx_data;
      end else begin
        drop = 1'b1;
      end
    end else if (hold_vld_q) begin
      if (timer_q == IDLE_MAX) begin
        // Close the frame; if the FIFO is full, stay here and retry.
        if (push_ok) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = {1'b1, hold_q};
          hold_vld_d   = 1'b0;
          timer_d      = '0;
        end
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tdata = fifo_rd_data[DATA_BITS-1:0];
  assign m_axis_tlast = fifo_rd_data[DATA_BITS];
  assign overflow     = overflow_q;
endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: self-checking bench for uart_rx_axis with a small FIFO and
// a short idle timeout. Expected beats come from the framing rule: a byte
// carries tlast when the next strobe comes more than IDLE+1 cycles later, or
// when it is the final byte before the line goes quiet.
module tb_uart_rx_axis;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int IDLE  = 200;
  localparam int CW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic overflow_clr = 1'b0;
  logic [CW-1:0] fifo_count;
  logic overflow;

  uart_rx_axis_if #(.DATA_BITS(DB)) axis ();

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_axis #(
    .DATA_BITS   (DB),
    .FIFO_DEPTH  (DEPTH),
    .IDLE_CYCLES (IDLE)
  ) dut (
    .clk           (clk),
    .rst           (rst_n),
    .rx_data       (axis.rx_data),
    .rx_valid      (axis.rx_valid),
    .m_axis_tdata  (axis.tdata),
    .m_axis_tvalid (axis.tvalid),
    .m_axis_tlast  (axis.tlast),
    .m_axis_tready (axis.tready),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [DB:0] exp_q[$];
  logic [DB:0] obs_q[$];
  int          obs_cyc_q[$];

  always @(negedge clk) begin
    if (rst_n && axis.tvalid && axis.tready) begin
      obs_q.push_back({axis.tlast, axis.tdata});
      obs_cyc_q.push_back(cyc);
    end
  end

  // reference model state
  bit          pend = 1'b0;
  logic [DB-1:0] pend_data = '0;
  int          pend_edge = 0;
  int          last_edge = 0;
  bit          rand_ready = 1'b0;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) axis.tready = ($urandom_range(0, 3) != 0);
  endtask

  // Strobe d so it is sampled 'gap' edges after the previous strobe.
  task automatic strobe(input logic [DB-1:0] d, input int gap);
    int target;
    target = last_edge + gap;
    while (cyc + 1 < target) tick();
    axis.rx_valid = 1'b1;
    axis.rx_data  = d;
    last_edge     = cyc + 1;
    if (pend) exp_q.push_back({(last_edge - pend_edge > IDLE + 1), pend_data});
    pend      = 1'b1;
    pend_data = d;
    pend_edge = last_edge;
    tick();
    axis.rx_valid = 1'b0;
  endtask

  task automatic flush();
    repeat (IDLE + 10) tick();
    if (pend) exp_q.push_back({1'b1, pend_data});
    pend = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    axis.rx_valid = 1'b0;
    axis.rx_data  = '0;
    axis.tready   = 1'b0;
    overflow_clr  = 1'b0;
    rand_ready    = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    pend      = 1'b0;
    last_edge = cyc;
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (axis.tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", axis.tvalid); else n_pass++;
    n_checks++; if (axis.tdata !== '0) $display("FAIL reset_tdata: got %h want 00", axis.tdata); else n_pass++;
    n_checks++; if (axis.tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", axis.tlast); else n_pass++;
    n_checks++; if (fifo_count !== '0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_frame_three();
    int s33;
    do_reset();
    axis.tready = 1'b1;
    strobe(8'h11, 0);
    strobe(8'h22, 100);
    strobe(8'h33, 100);
    s33 = last_edge;
    flush();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL frame3_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL frame3_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    if (obs_cyc_q.size() >= 3) begin
      n_checks++;
      if (obs_cyc_q[2] != s33 + IDLE + 1) $display("FAIL frame3_latency: got %0d want %0d", obs_cyc_q[2] - s33, IDLE + 1);
      else n_pass++;
    end
    n_checks++; if (axis.tvalid !== 1'b0) $display("FAIL frame3_idle_tvalid: got %b want 0", axis.tvalid); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    axis.tready = 1'b1;
    strobe(8'hA5, 0);
    flush();
    n_checks++; if (obs_q.size() != 1) $display("FAIL single_len: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0] !== {1'b1, 8'hA5}) $display("FAIL single_beat: got %h want %h", obs_q[0], {1'b1, 8'hA5}); else n_pass++;
    end
    n_checks++; if (axis.tvalid !== 1'b0) $display("FAIL single_tvalid_after: got %b want 0", axis.tvalid); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) strobe(8'h40 + 8'(i), 1);
    n_checks++; if (fifo_count !== CW'(DEPTH)) $display("FAIL ovf_count: got %0d want %0d", fifo_count, DEPTH); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    // drop and clear together: the drop keeps the flag set
    overflow_clr = 1'b1;
    strobe(8'h4F, 1);
    overflow_clr = 1'b0;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", overflow); else n_pass++;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
    // Bytes 0..DEPTH-1 sit in the FIFO, byte DEPTH in hold; later ones were dropped.
    exp_q.delete();
    pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({1'b0, 8'h40 + 8'(i)});
    exp_q.push_back({1'b1, 8'h40 + 8'(DEPTH)});
    axis.tready = 1'b1;
    repeat (IDLE + 20) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL ovf_drain_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL ovf_drain_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) strobe(8'h60 + 8'(i), 1);
    n_checks++; if (fifo_count !== CW'(DEPTH)) $display("FAIL fullpop_pre_count: got %0d want %0d", fifo_count, DEPTH); else n_pass++;
    axis.tready = 1'b1;
    strobe(8'h6F, 1);
    axis.tready = 1'b0;
    n_checks++; if (fifo_count !== CW'(DEPTH)) $display("FAIL fullpop_count: got %0d want %0d", fifo_count, DEPTH); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b want 0", overflow); else n_pass++;
    axis.tready = 1'b1;
    flush();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL fullpop_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL fullpop_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_idle_collision();
    do_reset();
    axis.tready = 1'b1;
    strobe(8'h77, 0);
    strobe(8'h88, IDLE + 1);   // lands on the expiry cycle: no tlast on 0x77
    strobe(8'h99, IDLE + 2);   // one cycle later: 0x88 closes its frame
    flush();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL collide_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL collide_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) strobe(8'hC0 + 8'(i), 1);
    n_checks++; if (axis.tvalid !== 1'b1) $display("FAIL midrst_pre_tvalid: got %b want 1", axis.tvalid); else n_pass++;
    n_checks++; if (fifo_count !== CW'(3)) $display("FAIL midrst_pre_count: got %0d want 3", fifo_count); else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (axis.tvalid !== 1'b0) $display("FAIL midrst_tvalid: got %b want 0", axis.tvalid); else n_pass++;
    n_checks++; if (axis.tdata !== '0) $display("FAIL midrst_tdata: got %h want 00", axis.tdata); else n_pass++;
    n_checks++; if (axis.tlast !== 1'b0) $display("FAIL midrst_tlast: got %b want 0", axis.tlast); else n_pass++;
    n_checks++; if (fifo_count !== '0) $display("FAIL midrst_count: got %0d want 0", fifo_count); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    pend = 1'b0;
    last_edge = cyc;
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
    axis.tready = 1'b1;
    strobe(8'h5A, 0);
    flush();
    n_checks++; if (obs_q.size() != 1) $display("FAIL midrst_post_len: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0] !== {1'b1, 8'h5A}) $display("FAIL midrst_post_beat: got %h want %h", obs_q[0], {1'b1, 8'h5A}); else n_pass++;
    end
  endtask

  task automatic test_random();
    int gap;
    int sel;
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      if (sel < 2)       gap = $urandom_range(6, 40);
      else if (sel == 2) gap = IDLE + 1;
      else               gap = IDLE + $urandom_range(2, 6);
      strobe(8'($urandom), gap);
    end
    flush();
    rand_ready  = 1'b0;
    axis.tready = 1'b1;
    repeat (20) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL random_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL random_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b0) $display("FAIL random_overflow: got %b want 0", overflow); else n_pass++;
  endtask

  // final report
  initial begin
    axis.rx_valid = 1'b0;
    axis.rx_data  = '0;
    axis.tready   = 1'b0;
    test_reset();
    test_frame_three();
    test_single();
    test_overflow();
    test_full_pop();
    test_idle_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
